// File: rtl/control_unit_mc.sv
// Multi-cycle control FSM for the 4-bit-opcode datapath with ready/valid memory handshake.
// Optional memory-timeout fault is enabled by defining CU_MEM_TIMEOUT_EN.
module control_unit_mc #(
  parameter int unsigned IFETCH_HS = 1,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cont,
  input  logic [3:0] op_code,
  input  logic       mem_ready,
  output logic       load_pc,
  output logic       load_ins,
  output logic       write_reg,
  output logic       mem_en,
  output logic       mem_wen,
  output logic       imm_sel,
  output logic [1:0] data_sel,
  output logic [2:0] branch,
  output logic       pwr,
  output logic       halted,
  output logic       ins_retired,
  output logic       mem_fault
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam logic [3:0] OP_ALU     = 4'h0;
  localparam logic [3:0] OP_ALU_IMM = 4'h1;
  localparam logic [3:0] OP_LOAD    = 4'h2;
  localparam logic [3:0] OP_STORE   = 4'h3;
  localparam logic [3:0] OP_BR      = 4'h4;
  localparam logic [3:0] OP_BMI     = 4'h5;
  localparam logic [3:0] OP_BPL     = 4'h6;
  localparam logic [3:0] OP_BZ      = 4'h7;
  localparam logic [3:0] OP_MOVE    = 4'h8;
  localparam logic [3:0] OP_CMOV    = 4'h9;
  localparam logic [3:0] OP_JR      = 4'hA;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam bit HS = (IFETCH_HS != 0);

  state_t     state;
  state_t     state_nxt;
  logic       timeout_hit;

  logic       load_pc_c;
  logic       load_ins_c;
  logic       write_reg_c;
  logic       mem_en_c;
  logic       mem_wen_c;
  logic       imm_sel_c;
  logic [1:0] data_sel_c;
  logic [2:0] branch_c;
  logic       pwr_c;
  logic       halted_c;
  logic       ins_retired_c;

`ifdef CU_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       waiting;

  assign waiting     = (((state == S_FETCH) && HS) || (state == S_MEM)) && !mem_ready;
  assign timeout_hit = waiting && (wait_cnt == 8'(TIMEOUT));

  // Wait-state counter, restarted whenever the FSM changes state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (state_nxt != state) begin
      wait_cnt <= 8'd0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= wait_cnt;
    end
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and raw control outputs
  always_comb begin
    state_nxt     = state;
    load_pc_c     = 1'b0;
    load_ins_c    = 1'b0;
    write_reg_c   = 1'b0;
    mem_en_c      = 1'b0;
    mem_wen_c     = 1'b0;
    imm_sel_c     = 1'b0;
    data_sel_c    = 2'b00;
    branch_c      = 3'b000;
    pwr_c         = 1'b1;
    halted_c      = 1'b0;
    ins_retired_c = 1'b0;
    case (state)
      S_FETCH: begin
        if (HS) begin
          mem_en_c = 1'b1;
          if (mem_ready) begin
            state_nxt = S_DECODE;
          end else if (timeout_hit) begin
            state_nxt = S_FAULT;
          end else begin
            state_nxt = S_FETCH;
          end
        end else begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        load_ins_c = 1'b1;
        state_nxt  = S_EXECUTE;
      end
      S_EXECUTE: begin
        if ((op_code == OP_LOAD) || (op_code == OP_STORE)) begin
          imm_sel_c = 1'b1;
          state_nxt = S_MEM;
        end else if ((op_code == OP_HALT) && !cont) begin
          state_nxt = S_HALTED;
        end else begin
          // Everything else, including released HALT and B/C/D/E, retires here
          load_pc_c     = 1'b1;
          ins_retired_c = 1'b1;
          state_nxt     = S_FETCH;
          case (op_code)
            OP_ALU:     write_reg_c = 1'b1;
            OP_ALU_IMM: begin imm_sel_c = 1'b1; write_reg_c = 1'b1; end
            OP_MOVE:    begin write_reg_c = 1'b1; data_sel_c = 2'b00; end
            OP_CMOV:    begin write_reg_c = 1'b1; data_sel_c = 2'b10; end
            OP_BR:      begin imm_sel_c = 1'b1; branch_c = 3'b001; end
            OP_BMI:     begin imm_sel_c = 1'b1; branch_c = 3'b010; end
            OP_BPL:     begin imm_sel_c = 1'b1; branch_c = 3'b011; end
            OP_BZ:      begin imm_sel_c = 1'b1; branch_c = 3'b100; end
            OP_JR:      branch_c = 3'b101;
            default:    branch_c = 3'b000;
          endcase
        end
      end
      S_MEM: begin
        imm_sel_c = 1'b1;
        mem_en_c  = 1'b1;
        mem_wen_c = (op_code == OP_STORE);
        if (mem_ready) begin
          if (op_code == OP_STORE) begin
            load_pc_c     = 1'b1;
            ins_retired_c = 1'b1;
            state_nxt     = S_FETCH;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          state_nxt = S_FAULT;
        end else begin
          state_nxt = S_MEM;
        end
      end
      S_WRITEBACK: begin
        mem_en_c      = 1'b1;
        data_sel_c    = 2'b01;
        write_reg_c   = 1'b1;
        load_pc_c     = 1'b1;
        ins_retired_c = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_HALTED: begin
        halted_c = 1'b1;
        pwr_c    = 1'b0;
        if (cont) begin
          load_pc_c     = 1'b1;
          ins_retired_c = 1'b1;
          state_nxt     = S_FETCH;
        end else begin
          state_nxt = S_HALTED;
        end
      end
      S_FAULT: begin
        halted_c  = 1'b1;
        pwr_c     = 1'b0;
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // Reset masks every strobe at once so an in-flight access is abandoned cleanly
  assign load_pc     = load_pc_c & ~reset;
  assign load_ins    = load_ins_c & ~reset;
  assign write_reg   = write_reg_c & ~reset;
  assign mem_en      = mem_en_c & ~reset;
  assign mem_wen     = mem_wen_c & ~reset;
  assign imm_sel     = imm_sel_c & ~reset;
  assign data_sel    = data_sel_c & {2{~reset}};
  assign branch      = branch_c & {3{~reset}};
  assign pwr         = pwr_c | reset;
  assign halted      = halted_c & ~reset;
  assign ins_retired = ins_retired_c & ~reset;

`ifdef CU_MEM_TIMEOUT_EN
  assign mem_fault = (state == S_FAULT) & ~reset;
`else
  assign mem_fault = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed scoreboard bench for control_unit_mc; expected output vectors are queued
// with each stimulus step and popped when the outputs are sampled.
module tb_control_unit_mc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cont = 1'b0;
  logic [3:0] op_code = 4'h0;
  logic       mem_ready = 1'b1;
  logic       load_pc, load_ins, write_reg, mem_en, mem_wen, imm_sel;
  logic [1:0] data_sel;
  logic [2:0] branch;
  logic       pwr, halted, ins_retired, mem_fault;

  int n_cmp = 0;
  int n_bad = 0;

  logic [14:0] exp_q[$];
  string       tag_q[$];

  control_unit_mc #(.IFETCH_HS(1), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .cont(cont), .op_code(op_code), .mem_ready(mem_ready),
    .load_pc(load_pc), .load_ins(load_ins), .write_reg(write_reg), .mem_en(mem_en),
    .mem_wen(mem_wen), .imm_sel(imm_sel), .data_sel(data_sel), .branch(branch),
    .pwr(pwr), .halted(halted), .ins_retired(ins_retired), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  // {load_pc, load_ins, write_reg, mem_en, mem_wen, imm_sel, data_sel, branch, pwr, halted, ins_retired, mem_fault}
  function automatic logic [14:0] o(input logic lpc, lins, wr, men, mwen, imm,
                                    input logic [1:0] ds, input logic [2:0] br,
                                    input logic pw, hl, rt, mf);
    return {lpc, lins, wr, men, mwen, imm, ds, br, pw, hl, rt, mf};
  endfunction

  // Retire in EXECUTE: load_pc + ins_retired + pwr, plus per-opcode fields
  function automatic logic [14:0] ex(input logic wr, imm, input logic [1:0] ds, input logic [2:0] br);
    return o(1'b1, 1'b0, wr, 1'b0, 1'b0, imm, ds, br, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction

  logic [14:0] RST, FE, DEC, EXM, MEML, MEMS, WB, HLT, HREL, FLT;

  task automatic cyc(input logic r, mr, c, input logic [3:0] op, input logic [14:0] e, input string tag);
    logic [14:0] obs, want;
    string       t;
    @(negedge clk);
    reset = r; mem_ready = mr; cont = c; op_code = op;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    obs  = {load_pc, load_ins, write_reg, mem_en, mem_wen, imm_sel, data_sel, branch,
            pwr, halted, ins_retired, mem_fault};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", t, obs, want);
    end
  endtask

  task automatic instr(input logic [3:0] op, input logic [14:0] e_ex, input string tag);
    cyc(1'b0, 1'b1, 1'b0, op, FE,  {tag, "_fetch"});
    cyc(1'b0, 1'b1, 1'b0, op, DEC, {tag, "_decode"});
    cyc(1'b0, 1'b1, 1'b0, op, e_ex, {tag, "_exec"});
  endtask

  initial begin
    RST  = o(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0, 0, 0);
    FE   = o(0, 0, 0, 1, 0, 0, 2'b00, 3'b000, 1, 0, 0, 0);
    DEC  = o(0, 1, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0, 0, 0);
    EXM  = o(0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 1, 0, 0, 0);
    MEML = o(0, 0, 0, 1, 0, 1, 2'b00, 3'b000, 1, 0, 0, 0);
    MEMS = o(1, 0, 0, 1, 1, 1, 2'b00, 3'b000, 1, 0, 1, 0);
    WB   = o(1, 0, 1, 1, 0, 0, 2'b01, 3'b000, 1, 0, 1, 0);
    HLT  = o(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1, 0, 0);
    HREL = o(1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1, 1, 0);
    FLT  = o(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1, 0, 1);

    // Reset holds everything quiet, even mem_en in FETCH
    cyc(1'b1, 1'b1, 1'b0, 4'h0, RST, "reset");
    cyc(1'b1, 1'b1, 1'b1, 4'h3, RST, "reset_cont");

    // Single-cycle-execute opcodes
    instr(4'h0, ex(1'b1, 1'b0, 2'b00, 3'b000), "alu");
    instr(4'h1, ex(1'b1, 1'b1, 2'b00, 3'b000), "alu_imm");
    instr(4'h4, ex(1'b0, 1'b1, 2'b00, 3'b001), "br");
    instr(4'h5, ex(1'b0, 1'b1, 2'b00, 3'b010), "bmi");
    instr(4'h6, ex(1'b0, 1'b1, 2'b00, 3'b011), "bpl");
    instr(4'h7, ex(1'b0, 1'b1, 2'b00, 3'b100), "bz");
    instr(4'h8, ex(1'b1, 1'b0, 2'b00, 3'b000), "move");
    instr(4'h9, ex(1'b1, 1'b0, 2'b10, 3'b000), "cmov");
    instr(4'hA, ex(1'b0, 1'b0, 2'b00, 3'b101), "jr");
    instr(4'hE, ex(1'b0, 1'b0, 2'b00, 3'b000), "nop");
    instr(4'hC, ex(1'b0, 1'b0, 2'b00, 3'b000), "op_c");

    // Fetch wait states; a cont pulse here does nothing
    cyc(1'b0, 1'b0, 1'b1, 4'hF, FE, "fetch_wait1");
    cyc(1'b0, 1'b0, 1'b0, 4'hF, FE, "fetch_wait2");
    instr(4'h0, ex(1'b1, 1'b0, 2'b00, 3'b000), "alu_after_wait");

    // LOAD with three wait cycles in MEM: 8 cycles total
    instr(4'h2, EXM, "load");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 4'h2, MEML, "load_mem_wait");
    cyc(1'b0, 1'b1, 1'b0, 4'h2, MEML, "load_mem_ready");
    cyc(1'b0, 1'b1, 1'b0, 4'h2, WB, "load_wb");

    // STORE with zero-wait memory
    instr(4'h3, EXM, "store");
    cyc(1'b0, 1'b1, 1'b0, 4'h3, MEMS, "store_mem");

    // HALT held for 5 cycles, then released
    instr(4'hF, RST, "halt");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 4'hF, HLT, "halted");
    cyc(1'b0, 1'b0, 1'b1, 4'hF, HREL, "halt_release");
    cyc(1'b0, 1'b1, 1'b0, 4'h0, FE, "fetch_after_halt");
    cyc(1'b0, 1'b1, 1'b0, 4'h0, DEC, "decode_after_halt");
    cyc(1'b0, 1'b1, 1'b1, 4'hF, ex(1'b0, 1'b0, 2'b00, 3'b000), "halt_cont_nop");

`ifdef CU_MEM_TIMEOUT_EN
    // Memory never answers: fault after 5 MEM cycles, sticky until reset
    instr(4'h2, EXM, "to_load");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 4'h2, MEML, "to_mem_wait");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 4'h2, FLT, "to_fault");
    cyc(1'b1, 1'b1, 1'b0, 4'h0, RST, "to_reset");
    // Ready arriving when the counter reaches the limit wins
    instr(4'h2, EXM, "to_race_load");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 4'h2, MEML, "to_race_wait");
    cyc(1'b0, 1'b1, 1'b0, 4'h2, MEML, "to_race_ready");
    cyc(1'b0, 1'b1, 1'b0, 4'h2, WB, "to_race_wb");
`else
    // Without the timeout feature waits are unbounded
    instr(4'h2, EXM, "long_load");
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 4'h2, MEML, "long_mem_wait");
    cyc(1'b0, 1'b1, 1'b0, 4'h2, MEML, "long_mem_ready");
    cyc(1'b0, 1'b1, 1'b0, 4'h2, WB, "long_wb");
`endif

    // Reset in the middle of a LOAD access
    instr(4'h2, EXM, "rst_load");
    cyc(1'b0, 1'b0, 1'b0, 4'h2, MEML, "rst_load_mem");
    cyc(1'b1, 1'b1, 1'b0, 4'h2, RST, "rst_mid_access");
    cyc(1'b0, 1'b0, 1'b0, 4'h2, FE, "rst_release_fetch");
    instr(4'h8, ex(1'b1, 1'b0, 2'b00, 3'b000), "move_after_rst");

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
